// File: rtl/cartoon_ctrl_pkg.sv
// Shared types and helpers for the cartoon filter mode controller.
// Holds the mode state encoding and the threshold-per-level mapping.
package cartoon_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARM_ON  = 2'd1,
    ON      = 2'd2,
    ARM_OFF = 2'd3
  } cartoon_state_e;

  localparam int NUM_LEVELS = 4;
  localparam int LEVEL_W    = $clog2(NUM_LEVELS);

  // Level k maps to (k+1)*step; the product is formed 10 bits wide, then clamped to 255.
  function automatic logic [7:0] level_thresh(input logic [LEVEL_W-1:0] idx,
                                              input logic [7:0]         step);
    logic [9:0] prod;
    prod = ({{(10-LEVEL_W){1'b0}}, idx} + 10'd1) * {2'b00, step};
    return (prod > 10'd255) ? 8'hFF : prod[7:0];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low push-button: two-flop synchronizer, stability
// counter and a one-cycle press pulse on a debounced 1->0 transition.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic        sync_1;
  logic        sync_2;
  logic        stable;
  logic        armed;
  logic [1:0]  warm;
  logic [19:0] cnt;
  logic        settle;

  assign settle = (cnt == DEBOUNCE_CYCLES - 20'd1);

  // armed only rises once a real released level has passed the synchronizer,
  // so a key held down through reset never produces a press until re-pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      stable <= 1'b1;
      armed  <= 1'b0;
      warm   <= 2'b00;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
      warm   <= {warm[0], 1'b1};
      press  <= 1'b0;
      if (warm[1] && sync_2) begin
        armed <= 1'b1;
      end
      if (sync_2 != stable) begin
        if (settle) begin
          stable <= sync_2;
          cnt    <= '0;
          press  <= armed & ~sync_2;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cartoon_mode_ctrl.sv
// Frame-synchronous mode controller for the cartoon filter: debounced key
// requests are queued and only applied on a vsync falling edge.
import cartoon_ctrl_pkg::*;

module cartoon_mode_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]  THRESH_STEP     = 8'd48,
  parameter int          FRAME_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync_n,
  input  logic                   key_toggle_n,
  input  logic                   key_level_n,
  output logic                   cartoon_en,
  output logic [7:0]             edge_thresh,
  output logic                   pending,
  output logic [FRAME_CNT_W-1:0] frames_on,
  output logic [1:0]             dbg_state
);

  logic                   toggle_press;
  logic                   level_press;
  logic                   vsync_q;
  logic                   frame_start;
  cartoon_state_e         state_q;
  cartoon_state_e         state_d;
  logic [LEVEL_W-1:0]     level_idx;
  logic [LEVEL_W-1:0]     level_idx_d;
  logic                   level_dirty;
  logic                   level_dirty_d;
  logic [7:0]             edge_thresh_d;
  logic [FRAME_CNT_W-1:0] frames_on_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_toggle_db (
    .clk   (clk),
    .reset (reset),
    .key_n (key_toggle_n),
    .press (toggle_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_level_db (
    .clk   (clk),
    .reset (reset),
    .key_n (key_level_n),
    .press (level_press)
  );

  assign frame_start = vsync_q & ~vsync_n;
  assign dbg_state   = state_q;

  // A toggle press always wins over a coincident frame start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (toggle_press) state_d = ARM_ON;
      ARM_ON:  if (toggle_press) state_d = OFF;
               else if (frame_start) state_d = ON;
      ON:      if (toggle_press) state_d = ARM_OFF;
      ARM_OFF: if (toggle_press) state_d = ON;
               else if (frame_start) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  // A level press in the same cycle as a frame start defers the update a frame.
  always_comb begin
    level_idx_d   = level_idx;
    level_dirty_d = level_dirty;
    edge_thresh_d = edge_thresh;
    if (level_press) begin
      level_idx_d   = level_idx + 1'b1;
      level_dirty_d = 1'b1;
    end else if (frame_start && level_dirty) begin
      edge_thresh_d = level_thresh(level_idx, THRESH_STEP);
      level_dirty_d = 1'b0;
    end
  end

  always_comb begin
    frames_on_d = frames_on;
    if (state_q == ARM_ON && state_d == ON) begin
      frames_on_d = '0;
    end else if ((state_q == ON || state_q == ARM_OFF) && frame_start &&
                 (frames_on != {FRAME_CNT_W{1'b1}})) begin
      frames_on_d = frames_on + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q     <= 1'b1;
      state_q     <= OFF;
      level_idx   <= '0;
      level_dirty <= 1'b0;
      edge_thresh <= THRESH_STEP;
      cartoon_en  <= 1'b0;
      pending     <= 1'b0;
      frames_on   <= '0;
    end else begin
      vsync_q     <= vsync_n;
      state_q     <= state_d;
      level_idx   <= level_idx_d;
      level_dirty <= level_dirty_d;
      edge_thresh <= edge_thresh_d;
      cartoon_en  <= (state_d == ON) || (state_d == ARM_OFF);
      pending     <= (state_d == ARM_ON) || (state_d == ARM_OFF) || level_dirty_d;
      frames_on   <= frames_on_d;
    end
  end

endmodule

// File: tb/tb_cartoon_mode_ctrl.sv
// Directed bench for cartoon_mode_ctrl with a short debounce window; a second
// instance with a larger threshold step covers threshold saturation.
module tb_cartoon_mode_ctrl;

  logic        clk;
  logic        reset;
  logic        vsync_n;
  logic        key_toggle_n;
  logic        key_level_n;
  logic        key_level2_n;
  logic        cartoon_en;
  logic [7:0]  edge_thresh;
  logic        pending;
  logic [15:0] frames_on;
  logic [1:0]  dbg_state;
  logic        cartoon_en2;
  logic [7:0]  edge_thresh2;
  logic        pending2;
  logic [15:0] frames_on2;
  logic [1:0]  dbg_state2;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] S_OFF = 2'd0, S_ARM_ON = 2'd1, S_ON = 2'd2, S_ARM_OFF = 2'd3;

  cartoon_mode_ctrl #(.DEBOUNCE_CYCLES(20'd4), .THRESH_STEP(8'd48), .FRAME_CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .vsync_n      (vsync_n),
    .key_toggle_n (key_toggle_n),
    .key_level_n  (key_level_n),
    .cartoon_en   (cartoon_en),
    .edge_thresh  (edge_thresh),
    .pending      (pending),
    .frames_on    (frames_on),
    .dbg_state    (dbg_state)
  );

  cartoon_mode_ctrl #(.DEBOUNCE_CYCLES(20'd4), .THRESH_STEP(8'd100), .FRAME_CNT_W(16)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .vsync_n      (vsync_n),
    .key_toggle_n (1'b1),
    .key_level_n  (key_level2_n),
    .cartoon_en   (cartoon_en2),
    .edge_thresh  (edge_thresh2),
    .pending      (pending2),
    .frames_on    (frames_on2),
    .dbg_state    (dbg_state2)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vsync_n = 1'b0;
    cycles(3);
    vsync_n = 1'b1;
    cycles(3);
  endtask

  task automatic press_toggle();
    key_toggle_n = 1'b0;
    cycles(10);
    key_toggle_n = 1'b1;
    cycles(10);
  endtask

  task automatic glitch(input int n);
    key_toggle_n = 1'b0;
    cycles(n);
    key_toggle_n = 1'b1;
    cycles(8);
  endtask

  initial begin
    reset = 1'b1; vsync_n = 1'b1;
    key_toggle_n = 1'b1; key_level_n = 1'b1; key_level2_n = 1'b1;
    @(negedge clk);
    cycles(3);
    reset = 1'b0;
    cycles(1);
    check("rst_en",      cartoon_en,   0);
    check("rst_thresh",  edge_thresh,  48);
    check("rst_pending", pending,      0);
    check("rst_frames",  frames_on,    0);
    check("rst_state",   dbg_state,    S_OFF);
    check("rst_thresh2", edge_thresh2, 100);

    // toggle on: queued until the next vsync falling edge
    key_toggle_n = 1'b0;
    cycles(10);
    check("arm_pending", pending,   1);
    check("arm_en",      cartoon_en, 0);
    check("arm_state",   dbg_state, S_ARM_ON);
    key_toggle_n = 1'b1;
    cycles(10);
    check("arm_hold_en", cartoon_en, 0);
    vsync_n = 1'b0;
    cycles(1);
    check("on_en",      cartoon_en, 1);
    check("on_state",   dbg_state,  S_ON);
    check("on_pending", pending,    0);
    check("on_frames",  frames_on,  0);
    cycles(5);
    check("vsync_low_one_pulse", frames_on, 0);
    vsync_n = 1'b1;
    cycles(3);
    repeat (3) frame();
    check("frames_3", frames_on, 3);

    // bounce rejection
    glitch(2); glitch(3); glitch(2);
    check("bounce_state",   dbg_state,  S_ON);
    check("bounce_pending", pending,    0);
    check("bounce_en",      cartoon_en, 1);

    // five level presses in one frame (wrap to index 1); dut2 gets three
    for (int i = 0; i < 5; i++) begin
      key_level_n = 1'b0;
      if (i < 3) key_level2_n = 1'b0;
      cycles(8);
      key_level_n = 1'b1; key_level2_n = 1'b1;
      cycles(10);
    end
    check("lvl_pending",     pending,     1);
    check("lvl_thresh_hold", edge_thresh, 48);
    frame();
    check("lvl_thresh_wrap", edge_thresh,  96);
    check("lvl_thresh_sat",  edge_thresh2, 255);
    check("lvl_pending_clr", pending,      0);
    check("lvl_frames",      frames_on,    4);

    // toggle press coincides with frame start while ON
    key_toggle_n = 1'b0;
    cycles(6);
    vsync_n = 1'b0;
    cycles(1);
    check("sim_tog_state",   dbg_state,  S_ARM_OFF);
    check("sim_tog_en",      cartoon_en, 1);
    check("sim_tog_pending", pending,    1);
    check("sim_tog_frames",  frames_on,  5);
    cycles(2);
    vsync_n = 1'b1;
    cycles(1);
    key_toggle_n = 1'b1;
    cycles(10);
    check("sim_tog_hold_en", cartoon_en, 1);
    frame();
    check("off_state",   dbg_state,  S_OFF);
    check("off_en",      cartoon_en, 0);
    check("off_pending", pending,    0);
    check("off_frames",  frames_on,  6);
    frame();
    check("off_frames_hold", frames_on, 6);

    // level press coincides with frame start
    key_level_n = 1'b0;
    cycles(6);
    vsync_n = 1'b0;
    cycles(1);
    check("sim_lvl_thresh",  edge_thresh, 96);
    check("sim_lvl_pending", pending,     1);
    cycles(2);
    vsync_n = 1'b1;
    cycles(1);
    key_level_n = 1'b1;
    cycles(10);
    check("sim_lvl_hold", edge_thresh, 96);
    frame();
    check("sim_lvl_next",    edge_thresh, 144);
    check("sim_lvl_pend_cl", pending,     0);

    // cancel before vsync
    press_toggle();
    check("cancel_arm",  dbg_state, S_ARM_ON);
    press_toggle();
    check("cancel_state",   dbg_state,  S_OFF);
    check("cancel_pending", pending,    0);
    check("cancel_en",      cartoon_en, 0);
    frame();
    check("cancel_en_frame", cartoon_en, 0);
    check("cancel_frames",   frames_on,  6);

    // reset while ARM_OFF
    press_toggle();
    frame();
    check("re_on_en",     cartoon_en, 1);
    check("re_on_frames", frames_on,  0);
    press_toggle();
    check("re_arm_off", dbg_state, S_ARM_OFF);
    reset = 1'b1;
    cycles(1);
    check("mid_rst_en",      cartoon_en,  0);
    check("mid_rst_state",   dbg_state,   S_OFF);
    check("mid_rst_thresh",  edge_thresh, 48);
    check("mid_rst_pending", pending,     0);
    cycles(1);
    reset = 1'b0;
    cycles(2);

    // key held through reset must be released first
    key_toggle_n = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(15);
    check("held_state",   dbg_state, S_OFF);
    check("held_pending", pending,   0);
    key_toggle_n = 1'b1;
    cycles(10);
    key_toggle_n = 1'b0;
    cycles(10);
    check("repress_state",   dbg_state, S_ARM_ON);
    check("repress_pending", pending,   1);
    key_toggle_n = 1'b1;
    cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cartoon_mode_ctrl.md
Name: cartoon_mode_ctrl

Overview:
- Frame-synchronous controller for the cartoon filter stage; sits between the board push-buttons and the cartoon filter datapath.
- Debounces two active-low keys: a filter on/off toggle and an edge-threshold step.
- Queues each request and applies it only at a frame boundary, so the filter enable and the edge threshold never change mid-frame.
- Drives the filter's enable and the threshold used by the upstream edge detector.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000, cycles a key must be stable before the change is accepted (min 2).
- THRESH_STEP, 8'd48, threshold increment per level; level k (0..3) gives (k+1)*THRESH_STEP, saturated to 255.
- FRAME_CNT_W, 16, width of the frames-active counter.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- vsync_n  in  1  VGA vertical sync, active-low, already in the clk domain.
- key_toggle_n  in  1  raw on/off button, active-low, asynchronous.
- key_level_n  in  1  raw threshold-step button, active-low, asynchronous.
- cartoon_en  out  1  enable to the cartoon filter; changes only at a frame start.
- edge_thresh  out  8  edge-detector threshold; changes only at a frame start.
- pending  out  1  high while any queued request is waiting for a frame start.
- frames_on  out  FRAME_CNT_W  frames elapsed since the filter last turned on; saturates at max.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: cartoon_en=0, edge_thresh=THRESH_STEP (level 0), pending=0, frames_on=0, state OFF.
  - Queued level index = 0; debouncer stable state = 1 (released); synchronizers = 1.
- Key path (per key):
  - Two-flop synchronizer, then a counter that increments while the synced value differs from the stable value and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable value takes the synced value and the counter clears.
  - A 1→0 transition of the stable value emits a one-cycle press pulse.
  - Latency from a clean edge to the press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- frame_start: one-cycle pulse on a falling edge of vsync_n, using a registered copy (1→0).
  - vsync_n held low produces only one pulse.
- State machine (states OFF, ARM_ON, ON, ARM_OFF):
  - OFF: toggle press → ARM_ON.
  - ARM_ON: toggle press → OFF (cancel). Otherwise frame_start → ON; cartoon_en=1 and frames_on=0 at the same edge.
  - ON: toggle press → ARM_OFF.
  - ARM_OFF: toggle press → ON (cancel). Otherwise frame_start → OFF; cartoon_en=0.
  - Toggle press and frame_start in the same cycle: the press is taken first and the frame_start is ignored for that request.
    - Example: OFF + both → ARM_ON; the filter turns on at the next frame_start.
    - Example: ARM_ON + both → OFF.
- Threshold:
  - Each level press increments the queued index mod 4 (3→0 wraps) and sets a level-dirty flag.
  - On frame_start with level-dirty set: edge_thresh = min((idx+1)*THRESH_STEP, 255) and level-dirty clears.
  - Compute the product 10 bits wide before saturating.
  - Level press and frame_start in the same cycle: the increment takes effect; edge_thresh keeps its old value; level-dirty stays set for the next frame_start.
  - The threshold updates regardless of cartoon_en.
- pending = (state is ARM_ON or ARM_OFF) OR level-dirty. Registered; valid one cycle after the causing event.
- frames_on:
  - In ON or ARM_OFF, increments on each frame_start, saturating at all-ones.
  - Cleared on entry to ON from ARM_ON.
  - Holds its value in OFF.
- Reset asserted mid-operation:
  - All state returns to the reset values on the next edge, including queued requests and the debounce counters.
  - A key held through reset must be released and pressed again to register.

Decomposition:
- Package cartoon_ctrl_pkg holds:
  - state enum {OFF, ARM_ON, ON, ARM_OFF} (2 bits);
  - NUM_LEVELS=4;
  - the level-to-threshold function.
- One sub-module, key_debounce: synchronizer, counter and press pulse, with parameter DEBOUNCE_CYCLES. Instantiated twice.

Test Plan:
- Reset behaviour (DEBOUNCE_CYCLES=4 in all tests): reset asserted 3 cycles → cartoon_en=0, edge_thresh=48, pending=0, frames_on=0.
- Toggle press:
  - key_toggle_n low for 10 cycles → pending=1, cartoon_en stays 0 until the next vsync_n falling edge; cartoon_en=1 at that edge.
  - After 3 further frames, frames_on=3.
- Bounce rejection: pulses of 2, 3 then 2 cycles low on key_toggle_n → no state change, pending stays 0.
- Threshold wrap:
  - 5 level presses in one frame → at frame_start edge_thresh=96 (index 1 after the wrap).
  - With THRESH_STEP=100 and index 3 → edge_thresh=255.
- Simultaneous events:
  - In ON, the toggle press pulse coincides with frame_start → state ARM_OFF, cartoon_en stays 1 until the next frame_start.
  - A level pulse coincides with frame_start → edge_thresh changes one frame later.
- Cancel and reset:
  - ARM_ON then a second toggle press before vsync → OFF, pending=0, cartoon_en never rises.
  - reset asserted while ARM_OFF → cartoon_en=0 next cycle.
